// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants, FSM state encoding and dump payload type for the register-file dump reader.
// Also imported by the register file and its bench.
package regfile_dump_reader_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned IDX_WIDTH  = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    SEND0 = 3'd2,
    SEND1 = 3'd3,
    DONE  = 3'd4
  } dumpState_e;

  typedef struct packed {
    logic [IDX_WIDTH-1:0]  index;
    logic [DATA_WIDTH-1:0] data;
  } dumpWord_t;

endpackage

// File: rtl/regfile_dump_pairbuf.sv
// Two-entry capture buffer for one even/odd register pair, with a registered output word
// selected from the freshly captured A data or the held B entry.
module regfile_dump_pairbuf #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  capture,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] dataA,
  input  logic [DATA_WIDTH-1:0] dataB,
  output logic [DATA_WIDTH-1:0] buf0,
  output logic [DATA_WIDTH-1:0] buf1,
  output logic [DATA_WIDTH-1:0] wordOut
);
  import regfile_dump_reader_pkg::*;

  logic [DATA_WIDTH-1:0] wordNextC;

  // Output word: A data on capture, the odd entry once the even word is accepted.
  always_comb begin
    wordNextC = wordOut;
    if (capture) begin
      wordNextC = dataA;
    end else if (advance) begin
      wordNextC = buf1;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      buf0    <= '0;
      buf1    <= '0;
      wordOut <= '0;
    end else begin
      if (capture) begin
        buf0 <= dataA;
        buf1 <= dataB;
      end
      wordOut <= wordNextC;
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Read-only dump master: walks the register file two registers at a time through ports A/B
// and streams each word with its index over valid/ready, keeping an XOR checksum.
module regfile_dump_reader #(
  parameter int unsigned NUM_REGS   = regfile_dump_reader_pkg::NUM_REGS,
  parameter int unsigned DATA_WIDTH = regfile_dump_reader_pkg::DATA_WIDTH,
  parameter int unsigned IDX_WIDTH  = regfile_dump_reader_pkg::IDX_WIDTH
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [IDX_WIDTH-1:0]  ctrl_readRegA,
  output logic [IDX_WIDTH-1:0]  ctrl_readRegB,
  input  logic [DATA_WIDTH-1:0] data_readRegA,
  input  logic [DATA_WIDTH-1:0] data_readRegB,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [IDX_WIDTH-1:0]  dump_index,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);
  import regfile_dump_reader_pkg::*;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REGS - 1);

  dumpState_e            state;
  dumpState_e            stateNext;
  logic [IDX_WIDTH-1:0]  pairIdx;
  logic [IDX_WIDTH-1:0]  pairIdxNext;
  logic [IDX_WIDTH-1:0]  addrANext;
  logic [IDX_WIDTH-1:0]  addrBNext;
  logic [IDX_WIDTH-1:0]  indexNext;
  logic                  validNext;
  logic                  busyNext;
  logic                  doneNext;
  logic [DATA_WIDTH-1:0] checksumNext;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic                  captureC;
  logic                  advanceC;
  logic                  handshakeC;
  logic [IDX_WIDTH-1:0]  idxPlus1C;

  assign handshakeC = dump_valid && dump_ready;
  assign idxPlus1C  = pairIdx + IDX_WIDTH'(1);

  regfile_dump_pairbuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) uPairBuf (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .capture      (captureC),
    .advance      (advanceC),
    .dataA        (data_readRegA),
    .dataB        (data_readRegB),
    .buf0         (buf0),
    .buf1         (buf1),
    .wordOut      (dump_data)
  );

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state         <= IDLE;
      pairIdx       <= '0;
      ctrl_readRegA <= '0;
      ctrl_readRegB <= '0;
      dump_valid    <= 1'b0;
      dump_index    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      checksum      <= '0;
    end else begin
      state         <= stateNext;
      pairIdx       <= pairIdxNext;
      ctrl_readRegA <= addrANext;
      ctrl_readRegB <= addrBNext;
      dump_valid    <= validNext;
      dump_index    <= indexNext;
      busy          <= busyNext;
      done          <= doneNext;
      checksum      <= checksumNext;
    end
  end

  always_comb begin
    stateNext    = state;
    pairIdxNext  = pairIdx;
    addrANext    = ctrl_readRegA;
    addrBNext    = ctrl_readRegB;
    validNext    = dump_valid;
    indexNext    = dump_index;
    busyNext     = busy;
    doneNext     = 1'b0;
    checksumNext = checksum;
    captureC     = 1'b0;
    advanceC     = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          pairIdxNext  = '0;
          addrANext    = '0;
          addrBNext    = IDX_WIDTH'(1);
          checksumNext = '0;
          busyNext     = 1'b1;
          stateNext    = READ;
        end
      end
      READ: begin
        captureC  = 1'b1;
        validNext = 1'b1;
        indexNext = pairIdx;
        stateNext = SEND0;
      end
      SEND0: begin
        if (handshakeC) begin
          checksumNext = checksum ^ buf0;
          advanceC     = 1'b1;
          indexNext    = idxPlus1C;
          stateNext    = SEND1;
        end
      end
      SEND1: begin
        if (handshakeC) begin
          checksumNext = checksum ^ buf1;
          validNext    = 1'b0;
          if (idxPlus1C == LAST_IDX) begin
            doneNext  = 1'b1;
            stateNext = DONE;
          end else begin
            pairIdxNext = pairIdx + IDX_WIDTH'(2);
            addrANext   = pairIdx + IDX_WIDTH'(2);
            addrBNext   = pairIdx + IDX_WIDTH'(3);
            stateNext   = READ;
          end
        end
      end
      DONE: begin
        busyNext  = 1'b0;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // Abort drops the stream without a done pulse; a handshake on the same edge is discarded.
    if (abort && (state != IDLE)) begin
      stateNext    = IDLE;
      pairIdxNext  = pairIdx;
      addrANext    = ctrl_readRegA;
      addrBNext    = ctrl_readRegB;
      indexNext    = dump_index;
      validNext    = 1'b0;
      busyNext     = 1'b0;
      doneNext     = 1'b0;
      checksumNext = checksum;
      captureC     = 1'b0;
      advanceC     = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: a behavioural register file feeds the read ports,
// expected words are queued at start and popped on every accepted handshake.
module tb_regfile_dump_reader;
  import regfile_dump_reader_pkg::*;

  logic                  clock        = 1'b0;
  logic                  ctrl_reset_n = 1'b0;
  logic                  start        = 1'b0;
  logic                  abort        = 1'b0;
  logic                  dump_ready   = 1'b0;
  logic [IDX_WIDTH-1:0]  ctrl_readRegA;
  logic [IDX_WIDTH-1:0]  ctrl_readRegB;
  logic [DATA_WIDTH-1:0] data_readRegA;
  logic [DATA_WIDTH-1:0] data_readRegB;
  logic                  dump_valid;
  logic [IDX_WIDTH-1:0]  dump_index;
  logic [DATA_WIDTH-1:0] dump_data;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] checksum;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  dumpWord_t             expQ [$];

  int                    assertCount = 0;
  int                    failCount   = 0;
  int                    cycleCount  = 0;
  int                    doneCount   = 0;
  int                    doneCycle   = 0;
  int                    firstValid  = -1;
  int                    wordsSeen   = 0;
  logic [DATA_WIDTH-1:0] tbChecksum  = '0;
  bit                    readyRandom = 1'b0;
  bit                    addrCheck   = 1'b0;
  bit                    stalledPrev = 1'b0;
  logic [IDX_WIDTH-1:0]  prevIdx     = '0;
  logic [DATA_WIDTH-1:0] prevData    = '0;

  regfile_dump_reader dut (
    .clock         (clock),
    .ctrl_reset_n  (ctrl_reset_n),
    .start         (start),
    .abort         (abort),
    .ctrl_readRegA (ctrl_readRegA),
    .ctrl_readRegB (ctrl_readRegB),
    .data_readRegA (data_readRegA),
    .data_readRegB (data_readRegB),
    .dump_valid    (dump_valid),
    .dump_ready    (dump_ready),
    .dump_index    (dump_index),
    .dump_data     (dump_data),
    .busy          (busy),
    .done          (done),
    .checksum      (checksum)
  );

  assign data_readRegA = regs[ctrl_readRegA];
  assign data_readRegB = regs[ctrl_readRegB];

  always #5 clock = ~clock;
  always @(posedge clock) cycleCount++;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycleCount);
    end
  endtask

  // Monitor: drives ready, scores every accepted word, checks stall stability and port addressing.
  always @(negedge clock) begin
    if (!ctrl_reset_n) begin
      stalledPrev = 1'b0;
    end else begin
      if (stalledPrev) begin
        checkValue("stall_valid", 64'(dump_valid), 64'd1);
        checkValue("stall_index", 64'(dump_index), 64'(prevIdx));
        checkValue("stall_data", 64'(dump_data), 64'(prevData));
      end
      dump_ready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) begin
        doneCount++;
        doneCycle = cycleCount;
      end
      if (addrCheck && busy) begin
        checkValue("addrA_even", 64'(ctrl_readRegA[0]), 64'd0);
        checkValue("addrB_pair", 64'(ctrl_readRegB), 64'(ctrl_readRegA + IDX_WIDTH'(1)));
      end
      if (dump_valid && dump_ready && !abort) begin
        if (firstValid < 0) firstValid = cycleCount;
        if (expQ.size() == 0) begin
          checkValue("extra_word_idx", 64'(dump_index), 64'hFFFF_FFFF);
        end else begin
          dumpWord_t e;
          e = expQ.pop_front();
          checkValue("dump_index", 64'(dump_index), 64'(e.index));
          checkValue("dump_data", 64'(dump_data), 64'(e.data));
          tbChecksum ^= e.data;
          wordsSeen++;
        end
      end
      stalledPrev = dump_valid && !dump_ready && !abort;
      prevIdx     = dump_index;
      prevData    = dump_data;
    end
  end

  task automatic pushExpected();
    wordsSeen  = 0;
    firstValid = -1;
    tbChecksum = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      expQ.push_back('{index: IDX_WIDTH'(i), data: regs[i]});
    end
  endtask

  task automatic pulseStart(output int n0);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n0 = cycleCount;
    checkValue("start_busy", 64'(busy), 64'd1);
    checkValue("start_checksum_clear", 64'(checksum), 64'd0);
  endtask

  task automatic runDump(input bit checkLatency, input int reStartAt);
    int                    n0;
    int                    doneBefore;
    bit                    timedOut;
    logic [DATA_WIDTH-1:0] modelXor;
    doneBefore = doneCount;
    modelXor   = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) modelXor ^= regs[i];
    pushExpected();
    pulseStart(n0);
    if (reStartAt > 0) begin
      repeat (reStartAt) @(posedge clock);
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    timedOut = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clock);
      #1;
      if (doneCount != doneBefore) begin
        timedOut = 1'b0;
        break;
      end
    end
    checkValue("done_timeout", 64'(timedOut), 64'd0);
    if (checkLatency) begin
      checkValue("first_valid_cycle", 64'(firstValid - n0), 64'd1);
      checkValue("done_cycle", 64'(doneCycle - n0), 64'd48);
    end
    repeat (3) @(posedge clock);
    #1;
    checkValue("done_count", 64'(doneCount - doneBefore), 64'd1);
    checkValue("words_seen", 64'(wordsSeen), 64'(NUM_REGS));
    checkValue("queue_left", 64'(expQ.size()), 64'd0);
    checkValue("checksum", 64'(checksum), 64'(modelXor));
    checkValue("idle_busy", 64'(busy), 64'd0);
    checkValue("idle_valid", 64'(dump_valid), 64'd0);
  endtask

  initial begin
    int                    n0;
    int                    doneBefore;
    bit                    found;
    logic [DATA_WIDTH-1:0] partXor;

    for (int i = 0; i < int'(NUM_REGS); i++) regs[i] = 32'h0000_DEAD ^ DATA_WIDTH'(i);
    regs[0] = '0;

    // Reset state
    repeat (3) @(negedge clock);
    checkValue("rst_valid", 64'(dump_valid), 64'd0);
    checkValue("rst_busy", 64'(busy), 64'd0);
    checkValue("rst_done", 64'(done), 64'd0);
    checkValue("rst_checksum", 64'(checksum), 64'd0);
    checkValue("rst_data", 64'(dump_data), 64'd0);
    checkValue("rst_index", 64'(dump_index), 64'd0);
    checkValue("rst_addrA", 64'(ctrl_readRegA), 64'd0);
    checkValue("rst_addrB", 64'(ctrl_readRegB), 64'd0);
    ctrl_reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // 1: full dump, ready held high, latency checked
    runDump(1'b1, 0);

    // 2: random backpressure
    for (int i = 0; i < int'(NUM_REGS); i++) regs[i] = $urandom;
    readyRandom = 1'b1;
    runDump(1'b0, 0);
    readyRandom = 1'b0;

    // 3: abort during SEND1 of pair 5, then a clean dump
    doneBefore = doneCount;
    pushExpected();
    pulseStart(n0);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clock);
      #1;
      if (dump_valid && dump_index == IDX_WIDTH'(11)) begin
        found = 1'b1;
        break;
      end
    end
    checkValue("abort_found_idx11", 64'(found), 64'd1);
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    partXor = '0;
    for (int i = 0; i < 11; i++) partXor ^= regs[i];
    checkValue("abort_valid", 64'(dump_valid), 64'd0);
    checkValue("abort_busy", 64'(busy), 64'd0);
    checkValue("abort_checksum", 64'(checksum), 64'(partXor));
    checkValue("abort_words", 64'(wordsSeen), 64'd11);
    repeat (5) @(posedge clock);
    #1;
    checkValue("abort_no_done", 64'(doneCount - doneBefore), 64'd0);
    checkValue("abort_stays_idle", 64'(busy), 64'd0);
    expQ.delete();
    runDump(1'b1, 0);

    // 4: start re-pulsed while busy
    runDump(1'b1, 10);

    // 5: asynchronous reset mid-dump
    doneBefore = doneCount;
    pushExpected();
    pulseStart(n0);
    repeat (20) @(posedge clock);
    #3;
    ctrl_reset_n = 1'b0;
    #1;
    checkValue("arst_valid", 64'(dump_valid), 64'd0);
    checkValue("arst_busy", 64'(busy), 64'd0);
    checkValue("arst_checksum", 64'(checksum), 64'd0);
    checkValue("arst_data", 64'(dump_data), 64'd0);
    checkValue("arst_index", 64'(dump_index), 64'd0);
    checkValue("arst_addrA", 64'(ctrl_readRegA), 64'd0);
    expQ.delete();
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    checkValue("arst_idle_busy", 64'(busy), 64'd0);
    checkValue("arst_idle_valid", 64'(dump_valid), 64'd0);
    checkValue("arst_no_done", 64'(doneCount - doneBefore), 64'd0);

    // 6: all ones except reg0, address pairing checked throughout
    for (int i = 0; i < int'(NUM_REGS); i++) regs[i] = '1;
    regs[0] = '0;
    addrCheck = 1'b1;
    runDump(1'b1, 0);
    addrCheck = 1'b0;
    checkValue("checksum_ones", 64'(checksum), 64'h0000_0000_FFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Debug/verification read-side master for the 32x32 register file. On a start pulse it walks every register through the two read ports (A = even index, B = odd index), buffers each pair and streams them out one word per valid/ready handshake with the register index. It also accumulates an XOR checksum of all streamed words. It sits beside the writeback path, drives only ctrl_readRegA/ctrl_readRegB, and never writes the register file.

Parameters:
NUM_REGS, 32, number of registers walked; must be even, at most 32
DATA_WIDTH, 32, register data width
IDX_WIDTH, 5, register index width

Ports:
clock  in  1  system clock, rising-edge active
ctrl_reset_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin a dump; ignored while busy
abort  in  1  synchronous abort; returns to IDLE at the next edge
ctrl_readRegA  out  IDX_WIDTH  read address to regfile port A
ctrl_readRegB  out  IDX_WIDTH  read address to regfile port B
data_readRegA  in  DATA_WIDTH  regfile port A data, combinational from address
data_readRegB  in  DATA_WIDTH  regfile port B data
dump_valid  out  1  dump_index/dump_data valid
dump_ready  in  1  consumer accepts the current word
dump_index  out  IDX_WIDTH  register number of the current word
dump_data  out  DATA_WIDTH  register contents
busy  out  1  high from the edge that accepts start until the return to IDLE
done  out  1  one-cycle pulse after the last word is accepted
checksum  out  DATA_WIDTH  XOR of all words accepted since the last start

Behaviour:
- Interface: one clock, clock; reset is asynchronous and active-low, ctrl_reset_n.
- Reset values: state=IDLE, all outputs 0, pair index=0, buffers=0, checksum=0.
- States: IDLE, READ, SEND0, SEND1, DONE.
- IDLE: start=1 at an edge -> pair index=0, checksum=0, busy=1, go to READ.
- READ, one cycle: ctrl_readRegA=idx and ctrl_readRegB=idx+1, both registered. At the next edge, capture data_readRegA into buf0 and data_readRegB into buf1, then go to SEND0.
- SEND0: dump_valid=1, dump_index=idx, dump_data=buf0. On dump_valid&&dump_ready, checksum^=buf0 and go to SEND1.
- SEND1: dump_index=idx+1, dump_data=buf1. On handshake, checksum^=buf1. If idx+1==NUM_REGS-1, go to DONE; else idx+=2 and go to READ.
- DONE: done=1 for exactly one cycle, then IDLE with busy=0. checksum holds until the next start.
- dump_data and dump_index are stable while dump_valid=1 and dump_ready=0. dump_valid never drops without a handshake, except on abort or reset.
- Addresses hold their last value outside READ. The regfile is never re-read during SEND states.
- Latency with dump_ready held high: start accepted at edge E0; index 0 is valid after E1; each pair takes 3 cycles; the final handshake is at E48; done is high in the cycle after E48.
- start while busy: ignored.
- start and abort in the same IDLE cycle: abort wins, stay in IDLE.
- abort in any non-IDLE state: at the next edge, go to IDLE, dump_valid=0, busy=0, no done pulse, checksum keeps its partial value.
- Reset mid-dump: immediate return to reset values, regardless of clock.
- Register 0 is streamed exactly as read; no special-casing of the zero register.
- The index increment never wraps: the last pair is (NUM_REGS-2, NUM_REGS-1).

Decomposition:
- Shared package: state encoding constants (IDLE/READ/SEND0/SEND1/DONE), NUM_REGS, DATA_WIDTH, IDX_WIDTH.
- The same package is reused by the regfile and its bench.
- One natural sub-module: regfile_dump_pairbuf, a 2-entry capture buffer with a select output mux. FSM, index counter and checksum stay in the top.

Test Plan:
1. Regfile loaded with reg[i]=0x0000DEAD^i (reg0=0), dump_ready=1, pulse start -> 32 words, indices 0..31 in order, data matches; done pulses in the cycle after E48; checksum = XOR of all 32 values.
2. dump_ready toggled pseudo-randomly -> same word sequence, no duplicates or drops, dump_data/dump_index stable while stalled, done exactly once.
3. abort asserted during SEND1 of pair 5 -> next cycle IDLE, dump_valid=0, busy=0, no done. A new start then dumps from index 0 with checksum cleared.
4. start re-pulsed while busy -> ignored; still exactly 32 words and one done.
5. ctrl_reset_n dropped mid-dump, asynchronously between edges -> all outputs 0 immediately. After release, IDLE until start.
6. All registers 0xFFFFFFFF except reg0=0 -> checksum=0xFFFFFFFF (31 ones XORed); ctrl_readRegA is always even and ctrl_readRegB = ctrl_readRegA+1 while in READ.
